// File: rtl/sort_serializer.sv
// Streams one sorted 4-element frame per input handshake as a byte sequence, and registers per-frame stats.
// Defining SORT_SER_CHECK_EN adds a sticky order_err output that flags accepted frames that are not sorted.
module sort_serializer #(
  parameter int W       = 8,
  parameter int DESCEND = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] ra,
  input  logic [W-1:0] rb,
  input  logic [W-1:0] rc,
  input  logic [W-1:0] rd,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_last,
  output logic [W-1:0] range,
  output logic [W-1:0] median,
`ifdef SORT_SER_CHECK_EN
  output logic         order_err,
`endif
  output logic [7:0]   frame_cnt
);

  typedef enum logic [0:0] {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t       state_r;
  logic [W-1:0] buf_r [4];
  logic [1:0]   idx_r;
  logic [1:0]   idx_next_s;
  logic         accept_s;
  logic         beat_s;

  // Maps stream position to buffer slot (buffer always holds ra..rd in slots 0..3).
  function automatic logic [1:0] slot(input logic [1:0] pos);
    if (DESCEND != 0) begin
      return 2'd3 - pos;
    end else begin
      return pos;
    end
  endfunction

  assign in_ready   = (state_r == IDLE) | (out_valid & out_ready & out_last);
  assign accept_s   = in_valid & in_ready;
  assign beat_s     = out_valid & out_ready;
  assign idx_next_s = idx_r + 2'd1;

  // Frame capture, byte sequencing and per-frame statistics.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= IDLE;
      idx_r     <= 2'd0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      range     <= '0;
      median    <= '0;
      frame_cnt <= 8'd0;
      for (int i = 0; i < 4; i++) begin
        buf_r[i] <= '0;
      end
    end else begin
      if (accept_s) begin
        // Also covers the back-to-back reload on the final beat, so out_valid never drops.
        buf_r[0]  <= ra;
        buf_r[1]  <= rb;
        buf_r[2]  <= rc;
        buf_r[3]  <= rd;
        idx_r     <= 2'd0;
        state_r   <= SEND;
        out_valid <= 1'b1;
        out_last  <= 1'b0;
        out_data  <= (DESCEND != 0) ? rd : ra;
        range     <= rd - ra;
        median    <= {1'b0, rb[W-1:1]} + {1'b0, rc[W-1:1]} + {{(W-1){1'b0}}, rb[0] & rc[0]};
        frame_cnt <= frame_cnt + 8'd1;
      end else if ((state_r == SEND) && beat_s) begin
        if (idx_r == 2'd3) begin
          state_r   <= IDLE;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
        end else begin
          idx_r    <= idx_next_s;
          out_data <= buf_r[slot(idx_next_s)];
          out_last <= (idx_next_s == 2'd3);
        end
      end
    end
  end

`ifdef SORT_SER_CHECK_EN
  function automatic logic out_of_order(input logic [W-1:0] a, b, c, d);
    return (a > b) | (b > c) | (c > d);
  endfunction

  // Sticky ordering error, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      order_err <= 1'b0;
    end else if (accept_s && out_of_order(ra, rb, rc, rd)) begin
      order_err <= 1'b1;
    end
  end
`endif

endmodule
